aes256_key_expand: RTL and testbench
====================================

# aes256_key_expand

Sequential AES-256 key-schedule engine sitting directly upstream of the AES round datapath. It latches a 256-bit cipher key and emits the 15 round keys (indices 0..14) as 128-bit words, one per accepted handshake. The round stage consumes round key *r* for round *r*. Each 4-word group needs exactly one SubWord, so four S-box instances cover one round key per cycle.

## Interface
- No parameters; AES-256 only (Nk=8, Nr=14).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- key  in  256  cipher key; key[255:224] = w[0]
- busy  out  1  high from cycle after accepted start until final key accepted
- rk_valid  out  1  rk/rk_idx hold a valid round key
- rk_ready  in  1  consumer accepts when rk_valid && rk_ready
- rk_idx  out  4  round-key index 0..14
- rk  out  128  round key; rk[127:96] = first word of the group
- done  out  1  one-cycle pulse after round key 14 is accepted

## Operation
- FSM states: IDLE and RUN.
- IDLE, on start: latch key into a 256-bit window {w[i-8..i-1]}, drive rk=key[255:128], rk_idx=0, rk_valid=1, and go to RUN.
- RUN, on handshake with rk_idx=0: drive rk=key[127:0], rk_idx=1.
- RUN, on handshake with rk_idx=r, 1≤r≤13: compute key r+1 from the window, present it, set rk_idx=r+1, and update window <= {window[127:0], new key}.
- Computing round key r≥2 from words w[4r..4r+3]:
  - r even: temp = SubWord(RotWord(w[4r-1])) ^ {Rcon[r/2],24'h0}.
  - r odd: temp = SubWord(w[4r-1]).
  - w[4r] = w[4r-8]^temp; w[4r+k] = w[4r+k-8]^w[4r+k-1] for k=1..3, chained combinationally.
- Rcon[1..7] = 01,02,04,08,10,20,40.
- RUN, on handshake with rk_idx=14: rk_valid=0, busy=0, done=1 for one cycle, go to IDLE.
- Without a handshake (rk_ready low), rk, rk_idx and rk_valid hold stable. No change is allowed while stalled.
- start while busy is ignored. The key input is sampled only at the accepted start.
- start in the same cycle as the final handshake is ignored. A new start is accepted from the next cycle.

## Timing
- Reset values: busy=0, rk_valid=0, rk_idx=0, rk=0, done=0, window=0, FSM=IDLE.
- rst mid-operation aborts immediately. No done pulse is produced.
- Start accepted at cycle t gives rk_valid=1 at t+1.
- With rk_ready held high:
  - key r appears at t+1+r.
  - last handshake completes at t+15.
  - done=1 at t+16, the same cycle busy falls.
- Throughput is 1 round key/cycle. All outputs are registered; there is no combinational path from rk_ready to any output.

## Configuration
- AES_KEY_STORE_EN defined:
  - every emitted round key is also written into an internal 15x128 register file.
  - adds ports rd_idx in 4 and rd_key out 128, a combinational read.
  - rd_idx>14 reads 0.
  - the file is cleared by rst and overwritten by the next start.
  - the round stage reuses keys across blocks without re-expansion.
- Undefined: no storage and no rd_* ports; each block requires a fresh expansion.

## Structure
- Shared package aes_pkg:
  - typedef aes_word_t (32b) and aes_block_t (128b).
  - AES_NR=14.
  - Rcon constant array.
  - S-box constant table (256x8), shared with the round stage.
- Sub-module aes_sbox: combinational 8-bit lookup from aes_pkg. Four instances form SubWord.

## Test plan
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, rk_ready=1:
  - idx0 = 603deb1015ca71be2b73aef0857d7781.
  - idx2 = 9ba354118e6925afa51a8b5f2067fcde.
  - idx14 = fe4890d1e6188d0b046df344706c631e.
  - done at start+16.
- Same key with rk_ready toggled pseudo-randomly: identical 15-key sequence, and rk stays stable whenever valid&&!ready.
- start pulsed at cycles 3 and 7 of a running expansion: both ignored; sequence and latency are unchanged.
- rst asserted while rk_idx=6:
  - next cycle all outputs are 0 and the FSM is IDLE.
  - a new start produces a correct idx0.
- All-zero key: idx2 = 62636363626363636263636362636363.
- With AES_KEY_STORE_EN: after the A.3 expansion, rd_idx=14 returns fe4890d1…631e and rd_idx=15 returns 0.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_pkg : AES word/block types, round count, Rcon and S-box tables      |
// | rev 1.0 : initial release                                               |
// +-----------------------------------------------------------------------+
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int AES_NR = 14;

  localparam logic [7:0] AES_RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [7:0] AES_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Out-of-range indices return 0 so callers need not guard the lookup.
  function automatic logic [7:0] aes_rcon(input logic [3:0] n);
    if (n >= 4'd1 && n <= 4'd7) return AES_RCON[n[2:0]];
    return 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_key_expand_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes256_key_expand_if : start/key request and round-key stream bundle   |
// | Optional read port under AES_KEY_STORE_EN.  rev 1.0 : initial release |
// +-----------------------------------------------------------------------+
interface aes256_key_expand_if;
  import aes_pkg::*;

  logic         start;
  logic [255:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_idx;
  aes_block_t   rk;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  aes_block_t   rd_key;
`endif

  modport slave (
    input  start, key, rk_ready,
`ifdef AES_KEY_STORE_EN
    input  rd_idx,
    output rd_key,
`endif
    output busy, rk_valid, rk_idx, rk, done
  );

  modport master (
    output start, key, rk_ready,
`ifdef AES_KEY_STORE_EN
    output rd_idx,
    input  rd_key,
`endif
    input  busy, rk_valid, rk_idx, rk, done
  );

endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_sbox : combinational AES forward S-box byte lookup                  |
// | rev 1.0 : initial release                                               |
// +-----------------------------------------------------------------------+
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = AES_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/aes256_key_expand.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes256_key_expand : AES-256 key schedule, one round key per handshake  |
// | AES_KEY_STORE_EN adds a 15x128 round-key file.  rev 1.0 : initial      |
// +-----------------------------------------------------------------------+
module aes256_key_expand
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  aes256_key_expand_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [255:0] window_q, window_d;
  aes_block_t   rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         w_accept, w_hs, w_last;
  aes_word_t    w_prev, w_sub_in, w_sub_out, w_temp;
  aes_word_t    w_k0, w_k1, w_k2, w_k3;
  aes_block_t   w_next_rk;

  assign w_accept = (state_q == ST_IDLE) && bus.start;
  assign w_hs     = (state_q == ST_RUN) && valid_q && bus.rk_ready;
  assign w_last   = (idx_q == 4'(AES_NR));

  // Odd current index means the key being built is even: rotate and add Rcon.
  assign w_prev   = window_q[31:0];
  assign w_sub_in = idx_q[0] ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_sub_in[8*b +: 8]),
      .o_byte (w_sub_out[8*b +: 8])
    );
  end

  assign w_temp    = w_sub_out ^ (idx_q[0] ? {aes_rcon({1'b0, idx_q[3:1]} + 4'd1), 24'h0} : 32'h0);
  assign w_k0      = window_q[255:224] ^ w_temp;
  assign w_k1      = window_q[223:192] ^ w_k0;
  assign w_k2      = window_q[191:160] ^ w_k1;
  assign w_k3      = window_q[159:128] ^ w_k2;
  assign w_next_rk = {w_k0, w_k1, w_k2, w_k3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      window_q <= '0;
      rk_q     <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      rk_q     <= rk_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept)         state_d = ST_RUN;
      ST_RUN:  if (w_hs && w_last)   state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    window_d = window_q;
    rk_d     = rk_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          window_d = bus.key;
          rk_d     = bus.key[255:128];
          idx_d    = 4'd0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_hs) begin
          if (w_last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (idx_q == 4'd0) begin
            // The second half of the cipher key is round key 1 verbatim.
            rk_d  = window_q[127:0];
            idx_d = 4'd1;
          end else begin
            rk_d     = w_next_rk;
            idx_d    = idx_q + 4'd1;
            window_d = {window_q[127:0], w_next_rk};
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = valid_q;
  assign bus.rk_idx   = idx_q;
  assign bus.rk       = rk_q;
  assign bus.done     = done_q;

`ifdef AES_KEY_STORE_EN
  aes_block_t store_q [AES_NR+1];
  aes_block_t store_d [AES_NR+1];

  always_comb begin
    store_d = store_q;
    if (w_accept) begin
      store_d    = '{default: '0};
      store_d[0] = bus.key[255:128];
    end else if (w_hs && !w_last) begin
      store_d[idx_d] = rk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) store_q <= '{default: '0};
    else     store_q <= store_d;
  end

  assign bus.rd_key = (bus.rd_idx <= 4'(AES_NR)) ? store_q[bus.rd_idx] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes256_key_expand.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_aes256_key_expand : randomized bench with FIPS-197 key-schedule model|
// | rev 1.0 : initial release                                               |
// +-----------------------------------------------------------------------+
module tb_aes256_key_expand;

  localparam logic [255:0] KEY_A3 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] A3_IDX0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_IDX2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_IDX14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z_IDX2   = 128'h62636363626363636263636362636363;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  aes256_key_expand_if bus ();

  aes256_key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box derived from GF(2^8) inversion plus affine map, independent of the RTL table.
  logic [7:0] m_sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
  endfunction

  logic [31:0]  m_w [60];
  logic         m_valid, m_busy, m_done, m_after_rst;
  logic [3:0]   m_idx;
  logic [127:0] m_rk;
  logic [127:0] m_store [15];

  task automatic expand(input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) m_w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = m_w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      m_w[i] = m_w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_of(input int r);
    return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
  endfunction

  // Transaction-level model: a key is issued, consumed on each handshake, done after the 15th.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_idx = 4'd0; m_rk = '0;
      m_after_rst = 1'b1;
      for (int i = 0; i < 15; i++) m_store[i] = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy && bus.start) begin
        expand(bus.key);
        m_idx = 4'd0; m_rk = rk_of(0); m_valid = 1'b1; m_busy = 1'b1;
        m_after_rst = 1'b0;
        for (int i = 0; i < 15; i++) m_store[i] = '0;
        m_store[0] = m_rk;
      end else if (m_valid && bus.rk_ready) begin
        if (m_idx == 4'd14) begin
          m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_idx = m_idx + 4'd1;
          m_rk  = rk_of(int'(m_idx));
          m_store[m_idx] = m_rk;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("busy",     128'(bus.busy),     128'(m_busy));
      chk("rk_valid", 128'(bus.rk_valid), 128'(m_valid));
      chk("done",     128'(bus.done),     128'(m_done));
      if (m_valid || m_after_rst) begin
        chk("rk_idx", 128'(bus.rk_idx), 128'(m_idx));
        chk("rk",     bus.rk,           m_rk);
      end
    end
  end

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic wait_done(input string name, input int budget, input bit rand_ready, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (rand_ready) bus.rk_ready = 1'($urandom_range(0, 1));
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk(name, 128'd0, 128'd1);
  endtask

  task automatic kick(input logic [255:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int lat;
  logic [255:0] k;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv, s;
      inv = 8'h01;
      if (i == 0) inv = 8'h00;
      else for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(i));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      m_sbox[i] = s;
    end
    bus.start = 1'b0; bus.key = '0; bus.rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
    bus.rd_idx = 4'd0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.3 key with the consumer always ready.
    bus.rk_ready = 1'b1;
    kick(KEY_A3);
    chk("a3_idx0", bus.rk, A3_IDX0);
    chk("model_a3_idx2",  rk_of(2),  A3_IDX2);
    chk("model_a3_idx14", rk_of(14), A3_IDX14);
    repeat (2) @(negedge clk);
    chk("a3_idx2", bus.rk, A3_IDX2);
    repeat (12) @(negedge clk);
    chk("a3_idx14", bus.rk, A3_IDX14);
    chk("a3_idx14_n", 128'(bus.rk_idx), 128'd14);
    @(negedge clk);
    chk("a3_done_t16", 128'(bus.done), 128'd1);
    chk("a3_busy_t16", 128'(bus.busy), 128'd0);
`ifdef AES_KEY_STORE_EN
    bus.rd_idx = 4'd14; #1;
    chk("store_14", bus.rd_key, A3_IDX14);
    bus.rd_idx = 4'd15; #1;
    chk("store_15", bus.rd_key, 128'd0);
    for (int i = 0; i < 15; i++) begin
      bus.rd_idx = 4'(i); #1;
      chk("store_all", bus.rd_key, m_store[i]);
    end
`endif
    @(negedge clk);

    // Same key with pseudo-random back-pressure.
    kick(KEY_A3);
    wait_done("rand_a3_timeout", 400, 1'b1, lat);
    bus.rk_ready = 1'b1;
    @(negedge clk);

    // Spurious starts at cycles 3 and 7 must not disturb sequence or latency.
    bus.key = KEY_A3; bus.start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == 3 || c == 7);
      bus.key   = rand_key();
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    bus.start = 1'b0;
    chk("spurious_start_latency", 128'(lat), 128'd16);
    @(negedge clk);

    // Reset while round key 6 is on the output.
    kick(rand_key());
    for (int c = 0; c < 40; c++) begin
      if (bus.rk_valid && bus.rk_idx == 4'd6) break;
      @(negedge clk);
    end
    chk("reached_idx6", 128'(bus.rk_idx), 128'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rk", bus.rk, 128'd0);
    chk("rst_valid", 128'(bus.rk_valid), 128'd0);
`ifdef AES_KEY_STORE_EN
    bus.rd_idx = 4'd0; #1;
    chk("rst_store", bus.rd_key, 128'd0);
`endif
    k = rand_key();
    kick(k);
    chk("post_rst_idx0", bus.rk, k[255:128]);
    wait_done("post_rst_timeout", 40, 1'b0, lat);
    @(negedge clk);

    // All-zero key.
    kick(256'd0);
    repeat (2) @(negedge clk);
    chk("zero_idx2", bus.rk, Z_IDX2);
    wait_done("zero_timeout", 40, 1'b0, lat);

    // Random keys under random back-pressure; a start lands on the done cycle.
    for (int n = 0; n < 5; n++) begin
      kick(rand_key());
      wait_done("rand_timeout", 400, 1'b1, lat);
    end
    bus.rk_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
